// File: rtl/alu_exec_unit_pkg.sv
// Shared superscalar definitions for the ALU execution units:
// the func_sel encodings, CDB tag constants and the default-width pipeline stage record.
package alu_exec_unit_pkg;

    // Operation select encodings; the codes above ALU_PASS_B are unused and yield zero
    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_SUB    = 4'b0001,
        ALU_SLL    = 4'b0010,
        ALU_SLT    = 4'b0011,
        ALU_SLTU   = 4'b0100,
        ALU_XOR    = 4'b0101,
        ALU_SRL    = 4'b0110,
        ALU_SRA    = 4'b0111,
        ALU_OR     = 4'b1000,
        ALU_AND    = 4'b1001,
        ALU_PASS_B = 4'b1010
    } alu_func_e;

    // CDB source tags, one per ALU; 2'b11 is reserved to mark a value as already valid
    localparam logic [1:0] TAG_ALU0  = 2'b00;
    localparam logic [1:0] TAG_ALU1  = 2'b01;
    localparam logic [1:0] TAG_ALU2  = 2'b10;
    localparam logic [1:0] TAG_VALID = 2'b11;

    // Default datapath widths of the core
    localparam int EXEC_DATA_WIDTH = 32;
    localparam int EXEC_PREG_WIDTH = 6;

    // One pipeline stage at the core's default widths
    typedef struct packed {
        logic                       valid;
        logic [EXEC_DATA_WIDTH-1:0] result;
        logic [EXEC_PREG_WIDTH-1:0] rd_phys_addr;
    } exec_stage_t;

endpackage

// File: rtl/alu_exec_datapath.sv
// Combinational ALU: result = f(data_a, data_b, func_sel).
// Shifts use only the low log2(DATA_WIDTH) bits of data_b; compares return a zero-extended 0/1.
module alu_exec_datapath
    import alu_exec_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic [3:0]            func_sel,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);

    logic [SHAMT_WIDTH-1:0] shamt;

    assign shamt = data_b[SHAMT_WIDTH-1:0];

    // Select the operation result; unassigned encodings give zero
    always_comb begin
        result = '0;
        case (func_sel)
            ALU_ADD:    result = data_a + data_b;
            ALU_SUB:    result = data_a - data_b;
            ALU_SLL:    result = data_a << shamt;
            ALU_SLT:    result = {{(DATA_WIDTH-1){1'b0}}, ($signed(data_a) < $signed(data_b))};
            ALU_SLTU:   result = {{(DATA_WIDTH-1){1'b0}}, (data_a < data_b)};
            ALU_XOR:    result = data_a ^ data_b;
            ALU_SRL:    result = data_a >> shamt;
            ALU_SRA:    result = $unsigned($signed(data_a) >>> shamt);
            ALU_OR:     result = data_a | data_b;
            ALU_AND:    result = data_a & data_b;
            ALU_PASS_B: result = data_b;
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit sitting behind one reservation station.
// Fixed-latency pipeline (LATENCY stages) that holds its result on the CDB until granted.
// The whole pipeline stalls while the last stage waits for a grant; flush kills every stage.
// issue_ready is combinational from cdb_grant and flush.
// Optional build macro ALU_EXEC_PERF_CNT_EN adds saturating issue/stall counters.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int         DATA_WIDTH          = 32,
    parameter int         PHYS_REG_ADDR_WIDTH = 6,
    parameter logic [1:0] FU_TAG              = TAG_ALU0,
    parameter int         LATENCY             = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           issue_valid,
    output logic                           issue_ready,
    input  logic [DATA_WIDTH-1:0]          data_a,
    input  logic [DATA_WIDTH-1:0]          data_b,
    input  logic [3:0]                     func_sel,
    input  logic [PHYS_REG_ADDR_WIDTH-1:0] rd_phys_addr,
    output logic                           cdb_valid,
    output logic [1:0]                     cdb_tag,
    output logic [DATA_WIDTH-1:0]          cdb_data,
    output logic [PHYS_REG_ADDR_WIDTH-1:0] cdb_dest_reg,
    input  logic                           cdb_grant,
    output logic                           busy
`ifdef ALU_EXEC_PERF_CNT_EN
    ,
    output logic [31:0]                    perf_issue_cnt,
    output logic [31:0]                    perf_stall_cnt
`endif
);

    // Stage record sized to this instance's widths
    typedef struct packed {
        logic                           valid;
        logic [DATA_WIDTH-1:0]          result;
        logic [PHYS_REG_ADDR_WIDTH-1:0] rd_phys_addr;
    } stage_t;

    stage_t                stages [LATENCY];
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  advance;
    logic                  issue_fire;

    alu_exec_datapath #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_datapath (
        .data_a   (data_a),
        .data_b   (data_b),
        .func_sel (func_sel),
        .result   (alu_result)
    );

    assign advance     = !(stages[LATENCY-1].valid && !cdb_grant);
    assign issue_ready = advance && !flush;
    assign issue_fire  = issue_valid && issue_ready;

    assign cdb_valid    = stages[LATENCY-1].valid;
    assign cdb_tag      = FU_TAG;
    assign cdb_data     = stages[LATENCY-1].result;
    assign cdb_dest_reg = stages[LATENCY-1].rd_phys_addr;

    // Pipeline shift: flush clears valids, stall holds everything, otherwise every stage moves on
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                stages[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < LATENCY; i++) begin
                stages[i].valid <= 1'b0;
            end
        end else if (advance) begin
            stages[0].valid <= issue_fire;
            if (issue_fire) begin
                stages[0].result       <= alu_result;
                stages[0].rd_phys_addr <= rd_phys_addr;
            end
            for (int i = 1; i < LATENCY; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    // Unit is busy while any stage holds a live op
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            busy = busy | stages[i].valid;
        end
    end

`ifdef ALU_EXEC_PERF_CNT_EN
    logic stall_cycle;

    assign stall_cycle = stages[LATENCY-1].valid && !cdb_grant;

    // Saturating counters of accepted issues and CDB stall cycles; flush does not touch them
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (issue_fire && (perf_issue_cnt != 32'hFFFF_FFFF)) begin
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            end
            if (stall_cycle && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit.
// Three instances (LATENCY 1, 2, 3) share the stimulus; each phase checks the instance it targets.
// Build with ALU_EXEC_PERF_CNT_EN to also exercise the performance counters.
module tb_alu_exec_unit;
    import alu_exec_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        issue_valid;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [3:0]  func_sel;
    logic [5:0]  rd_phys_addr;
    logic        cdb_grant;

    logic        ready1, cv1, busy1;
    logic [1:0]  tag1;
    logic [31:0] data1;
    logic [5:0]  dest1;
    logic        ready2, cv2, busy2;
    logic [1:0]  tag2;
    logic [31:0] data2;
    logic [5:0]  dest2;
    logic        ready3, cv3, busy3;
    logic [1:0]  tag3;
    logic [31:0] data3;
    logic [5:0]  dest3;
`ifdef ALU_EXEC_PERF_CNT_EN
    logic [31:0] pic1, psc1, pic2, psc2, pic3, psc3;
`endif

    int checks;
    int failures;

    typedef struct {
        logic [3:0]  func;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expected;
    } op_vec_t;

    op_vec_t vec [13];

    alu_exec_unit #(.DATA_WIDTH(32), .PHYS_REG_ADDR_WIDTH(6), .FU_TAG(TAG_ALU1), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset), .flush(flush), .issue_valid(issue_valid), .issue_ready(ready1),
        .data_a(data_a), .data_b(data_b), .func_sel(func_sel), .rd_phys_addr(rd_phys_addr),
        .cdb_valid(cv1), .cdb_tag(tag1), .cdb_data(data1), .cdb_dest_reg(dest1),
        .cdb_grant(cdb_grant), .busy(busy1)
`ifdef ALU_EXEC_PERF_CNT_EN
        , .perf_issue_cnt(pic1), .perf_stall_cnt(psc1)
`endif
    );

    alu_exec_unit #(.DATA_WIDTH(32), .PHYS_REG_ADDR_WIDTH(6), .FU_TAG(TAG_ALU2), .LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset), .flush(flush), .issue_valid(issue_valid), .issue_ready(ready2),
        .data_a(data_a), .data_b(data_b), .func_sel(func_sel), .rd_phys_addr(rd_phys_addr),
        .cdb_valid(cv2), .cdb_tag(tag2), .cdb_data(data2), .cdb_dest_reg(dest2),
        .cdb_grant(cdb_grant), .busy(busy2)
`ifdef ALU_EXEC_PERF_CNT_EN
        , .perf_issue_cnt(pic2), .perf_stall_cnt(psc2)
`endif
    );

    alu_exec_unit #(.DATA_WIDTH(32), .PHYS_REG_ADDR_WIDTH(6), .FU_TAG(TAG_ALU0), .LATENCY(3)) u_l3 (
        .clk(clk), .reset(reset), .flush(flush), .issue_valid(issue_valid), .issue_ready(ready3),
        .data_a(data_a), .data_b(data_b), .func_sel(func_sel), .rd_phys_addr(rd_phys_addr),
        .cdb_valid(cv3), .cdb_tag(tag3), .cdb_data(data3), .cdb_dest_reg(dest3),
        .cdb_grant(cdb_grant), .busy(busy3)
`ifdef ALU_EXEC_PERF_CNT_EN
        , .perf_issue_cnt(pic3), .perf_stall_cnt(psc3)
`endif
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input logic iv, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] f, input logic [5:0] rd,
                                 input logic g, input logic fl);
        issue_valid  = iv;
        data_a       = a;
        data_b       = b;
        func_sel     = f;
        rd_phys_addr = rd;
        cdb_grant    = g;
        flush        = fl;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic g);
        applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 6'd0, g, 1'b0);
    endtask

    task automatic doReset();
        reset = 1'b0;
        idle(1'b1);
        cycle();
        reset = 1'b1;
        #1;
    endtask

    // Directed sequence of all phases
    initial begin
        checks   = 0;
        failures = 0;
        vec = '{
            '{ALU_SRA,    32'h8000_0000, 32'd4,         32'hF800_0000},
            '{ALU_SLT,    32'hFFFF_FFFF, 32'd1,         32'd1},
            '{ALU_SLTU,   32'hFFFF_FFFF, 32'd1,         32'd0},
            '{4'b1111,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0},
            '{ALU_SLT,    32'd1,         32'hFFFF_FFFF, 32'd0},
            '{ALU_SLL,    32'd1,         32'd36,        32'h0000_0010},
            '{ALU_SRL,    32'h8000_0000, 32'd31,        32'd1},
            '{ALU_XOR,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0},
            '{ALU_OR,     32'h0F00_0000, 32'h0000_00F0, 32'h0F00_00F0},
            '{ALU_AND,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000},
            '{ALU_PASS_B, 32'h0000_1234, 32'hDEAD_BEEF, 32'hDEAD_BEEF},
            '{4'b1011,    32'd5,         32'd3,         32'd0},
            '{ALU_ADD,    32'hFFFF_FFFF, 32'd2,         32'd1}
        };

        // Reset values
        reset = 1'b0;
        idle(1'b1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", ready1, 1);
        checkOutput("rst_cdb_valid", cv1, 0);
        checkOutput("rst_cdb_data", data1, 0);
        checkOutput("rst_cdb_dest", dest1, 0);
        checkOutput("rst_busy", busy1, 0);
        reset = 1'b1;
        #1;

        // LATENCY=1 basic ADD / SUB with grant held high
        applyStimulus(1'b1, 32'd5, 32'd7, ALU_ADD, 6'd9, 1'b1, 1'b0);
        checkOutput("l1_ready", ready1, 1);
        cycle();
        checkOutput("l1_add_valid", cv1, 1);
        checkOutput("l1_add_data", data1, 32'd12);
        checkOutput("l1_add_dest", dest1, 32'd9);
        checkOutput("l1_tag", tag1, 32'(TAG_ALU1));
        applyStimulus(1'b1, 32'd0, 32'd1, ALU_SUB, 6'd10, 1'b1, 1'b0);
        cycle();
        checkOutput("l1_sub_valid", cv1, 1);
        checkOutput("l1_sub_data", data1, 32'hFFFF_FFFF);
        checkOutput("l1_sub_dest", dest1, 32'd10);

        // Operation sweep, one op per cycle back-to-back
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1'b1, vec[i].a, vec[i].b, vec[i].func, 6'(i + 16), 1'b1, 1'b0);
            cycle();
            checkOutput("op_valid", cv1, 1);
            checkOutput("op_data", data1, vec[i].expected);
            checkOutput("op_dest", dest1, 32'(i + 16));
        end
        idle(1'b1);
        cycle();
        checkOutput("l1_drain_valid", cv1, 0);
        checkOutput("l1_drain_busy", busy1, 0);

        // Backpressure on LATENCY=2
        doReset();
        applyStimulus(1'b1, 32'd1, 32'd1, ALU_ADD, 6'd1, 1'b0, 1'b0);
        checkOutput("bp_ready_c0", ready2, 1);
        cycle();
        applyStimulus(1'b1, 32'd2, 32'd2, ALU_ADD, 6'd2, 1'b0, 1'b0);
        checkOutput("bp_ready_c1", ready2, 1);
        checkOutput("bp_valid_c1", cv2, 0);
        cycle();
        applyStimulus(1'b1, 32'd3, 32'd3, ALU_ADD, 6'd3, 1'b0, 1'b0);
        checkOutput("bp_ready_c2", ready2, 0);
        checkOutput("bp_valid_c2", cv2, 1);
        checkOutput("bp_data_c2", data2, 32'd2);
        checkOutput("bp_dest_c2", dest2, 32'd1);
        cycle();
        checkOutput("bp_ready_c3", ready2, 0);
        checkOutput("bp_data_c3", data2, 32'd2);
        checkOutput("bp_dest_c3", dest2, 32'd1);
        applyStimulus(1'b1, 32'd3, 32'd3, ALU_ADD, 6'd3, 1'b1, 1'b0);
        checkOutput("bp_ready_c4", ready2, 1);
        checkOutput("bp_data_c4", data2, 32'd2);
        checkOutput("bp_dest_c4", dest2, 32'd1);
        cycle();
        idle(1'b1);
        checkOutput("bp_valid_c5", cv2, 1);
        checkOutput("bp_data_c5", data2, 32'd4);
        checkOutput("bp_dest_c5", dest2, 32'd2);
        cycle();
        checkOutput("bp_valid_c6", cv2, 1);
        checkOutput("bp_data_c6", data2, 32'd6);
        checkOutput("bp_dest_c6", dest2, 32'd3);
        cycle();
        checkOutput("bp_valid_c7", cv2, 0);
        checkOutput("bp_busy_c7", busy2, 0);

        // Flush with two ops in flight on LATENCY=3
        doReset();
        applyStimulus(1'b1, 32'd7, 32'd8, ALU_ADD, 6'd20, 1'b1, 1'b0);
        checkOutput("fl_ready_c0", ready3, 1);
        cycle();
        applyStimulus(1'b1, 32'd9, 32'd9, ALU_ADD, 6'd21, 1'b1, 1'b0);
        cycle();
        applyStimulus(1'b1, 32'd1, 32'd1, ALU_ADD, 6'd22, 1'b1, 1'b1);
        checkOutput("fl_ready_flush", ready3, 0);
        checkOutput("fl_busy_before", busy3, 1);
        cycle();
        idle(1'b1);
        checkOutput("fl_busy_after", busy3, 0);
        checkOutput("fl_valid_after", cv3, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            checkOutput("fl_never_on_cdb", cv3, 0);
        end
        applyStimulus(1'b1, 32'd40, 32'd2, ALU_ADD, 6'd23, 1'b1, 1'b0);
        checkOutput("fl_ready_resume", ready3, 1);
        cycle();
        idle(1'b1);
        cycle();
        checkOutput("fl_lat_early", cv3, 0);
        cycle();
        checkOutput("fl_lat_valid", cv3, 1);
        checkOutput("fl_lat_data", data3, 32'd42);
        checkOutput("fl_lat_dest", dest3, 32'd23);
        checkOutput("fl_tag", tag3, 32'(TAG_ALU0));

        // Asynchronous reset in the middle of a stall on LATENCY=2
        doReset();
        applyStimulus(1'b1, 32'd10, 32'd20, ALU_ADD, 6'd5, 1'b0, 1'b0);
        cycle();
        idle(1'b0);
        cycle();
        checkOutput("ar_stalled_valid", cv2, 1);
        checkOutput("ar_stalled_data", data2, 32'd30);
        reset = 1'b0;
        #1;
        checkOutput("ar_valid", cv2, 0);
        checkOutput("ar_data", data2, 0);
        checkOutput("ar_dest", dest2, 0);
        checkOutput("ar_busy", busy2, 0);
        checkOutput("ar_ready", ready2, 1);
        cycle();
        reset = 1'b1;
        applyStimulus(1'b1, 32'd100, 32'd1, ALU_ADD, 6'd7, 1'b1, 1'b0);
        checkOutput("ar_ready_after", ready2, 1);
        cycle();
        idle(1'b1);
        checkOutput("ar_lat_early", cv2, 0);
        cycle();
        checkOutput("ar_lat_valid", cv2, 1);
        checkOutput("ar_lat_data", data2, 32'd101);
        checkOutput("ar_lat_dest", dest2, 32'd7);
        cycle();

`ifdef ALU_EXEC_PERF_CNT_EN
        // Performance counters on LATENCY=2: 10 issues, 4 stall cycles, then saturation
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 32'(i), 32'd1, ALU_ADD, 6'(i), 1'b1, 1'b0);
            cycle();
        end
        idle(1'b0);
        repeat (4) cycle();
        idle(1'b1);
        repeat (3) cycle();
        checkOutput("perf_issue", pic2, 32'd10);
        checkOutput("perf_stall", psc2, 32'd4);
        force u_l2.perf_issue_cnt = 32'hFFFF_FFFE;
        force u_l2.perf_stall_cnt = 32'hFFFF_FFFE;
        #1;
        release u_l2.perf_issue_cnt;
        release u_l2.perf_stall_cnt;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'd1, 32'd1, ALU_ADD, 6'd1, 1'b1, 1'b0);
            cycle();
        end
        checkOutput("perf_issue_sat", pic2, 32'hFFFF_FFFF);
        idle(1'b0);
        repeat (3) cycle();
        checkOutput("perf_stall_sat", psc2, 32'hFFFF_FFFF);
        idle(1'b1);
        repeat (3) cycle();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
